// File: rtl/beep_pkg.sv
// ----------------------------------------------------------------------------
// beep_pkg
// Shared definitions for the whack-a-mole buzzer scheduler:
//   - default pattern length and note width
//   - sound source indices (hit, miss, game over)
//   - scheduler state encoding
//   - note ROM holding one half-period count per pattern step
//   - helpers for fixed-priority selection and one-hot grant encoding
// ----------------------------------------------------------------------------
package beep_pkg;

    // Default geometry; the note ROM below is laid out for these values.
    localparam int DEF_SEQ_LEN = 4;
    localparam int DEF_NOTE_W  = 16;

    localparam int NUM_SRC = 3;

    typedef logic [1:0]            src_t;
    typedef logic [NUM_SRC-1:0]    src_vec_t;
    typedef logic [DEF_NOTE_W-1:0] note_t;

    localparam src_t SRC_HIT  = 2'd0;
    localparam src_t SRC_MISS = 2'd1;
    localparam src_t SRC_OVER = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    // Half-period counts in clk_50MHz cycles; 0 means a rest.
    localparam note_t NOTES [NUM_SRC][DEF_SEQ_LEN] = '{
        '{16'd47801, 16'd37936, 16'd31888, 16'd0},  // hit
        '{16'd63776, 16'd0,     16'd63776, 16'd0},  // miss
        '{16'd47801, 16'd56818, 16'd63776, 16'd0}   // game over
    };

    // Highest-priority pending source: game over > miss > hit.
    // Only meaningful when at least one bit of p is set.
    function automatic src_t prio_pick(input src_vec_t p);
        if (p[SRC_OVER])
            return SRC_OVER;
        else if (p[SRC_MISS])
            return SRC_MISS;
        else
            return SRC_HIT;
    endfunction

    function automatic src_vec_t src_onehot(input src_t s);
        return src_vec_t'(3'b001 << s);
    endfunction

endpackage

// File: rtl/beep_scheduler_if.sv
// ----------------------------------------------------------------------------
// beep_scheduler_if
// Bundle between the game logic and the buzzer scheduler.
//   rhythm_tick  game -> sched  one-cycle 3 Hz pulse from the beep divider
//   req[2:0]     game -> sched  one-cycle requests: bit0 hit, bit1 miss,
//                               bit2 game over
//   busy         sched -> game  a pattern is armed or playing
//   grant[2:0]   sched -> game  one-hot source owning the buzzer, 0 if idle
//   note_idx     sched -> game  current step within the pattern
//   done         sched -> game  one-cycle pulse on completion or abort
//   beep         sched -> pin   square-wave buzzer drive
// Modports: master = game side, slave = scheduler.
// ----------------------------------------------------------------------------
interface beep_scheduler_if #(
    parameter int SEQ_LEN = 4
);
    localparam int IDX_W = $clog2(SEQ_LEN);

    logic             rhythm_tick;
    logic [2:0]       req;
    logic             busy;
    logic [2:0]       grant;
    logic [IDX_W-1:0] note_idx;
    logic             done;
    logic             beep;

    modport master (
        output rhythm_tick,
        output req,
        input  busy,
        input  grant,
        input  note_idx,
        input  done,
        input  beep
    );

    modport slave (
        input  rhythm_tick,
        input  req,
        output busy,
        output grant,
        output note_idx,
        output done,
        output beep
    );

endinterface

// File: rtl/beep_tone_gen.sv
// ----------------------------------------------------------------------------
// beep_tone_gen
// Square-wave generator for one note. A counter runs 0..half-1 and the
// output toggles each time it wraps, giving a period of 2*half cycles.
// Ports:
//   clk_50MHz  in   system clock
//   rst_n      in   synchronous reset, active-high
//   restart    in   clear counter and output (note change / entering PLAY)
//   half       in   half-period count; 0 means rest (output held low)
//   en         in   high while a note is playing; low holds everything at 0
//   beep       out  square-wave drive
// ----------------------------------------------------------------------------
module beep_tone_gen #(
    parameter int NOTE_W = 16
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [NOTE_W-1:0] half,
    input  logic              en,
    output logic              beep
);

    logic [NOTE_W-1:0] cnt;
    logic              beep_q;

    // A rest or a disabled generator behaves exactly like a restart so
    // the next real note always starts from a clean phase.
    logic hold;
    assign hold = restart || !en || (half == '0);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_50MHz) begin
        if (rst_n) begin
            cnt    <= '0;
            beep_q <= 1'b0;
        end else if (hold) begin
            cnt    <= '0;
            beep_q <= 1'b0;
        end else if (cnt == half - NOTE_W'(1)) begin
            cnt    <= '0;
            beep_q <= ~beep_q;
        end else begin
            cnt    <= cnt + NOTE_W'(1);
        end
    end

    assign beep = beep_q;

endmodule

// File: rtl/beep_scheduler.sv
// ----------------------------------------------------------------------------
// beep_scheduler
// Grants the single buzzer to one of three sound sources by fixed priority
// (game over > miss > hit), steps the granted source's pattern on each
// rhythm tick and drives the buzzer square wave.
// Ports:
//   clk_50MHz  in     system clock, 50 MHz
//   rst_n      in     synchronous reset, active-high (asserted = 1)
//   bus        slave  beep_scheduler_if: rhythm_tick, req in;
//                     busy, grant, note_idx, done, beep out
// Parameters:
//   SEQ_LEN    notes per pattern (power of two, >= 2)
//   NOTE_W     width of a note half-period count
// Build option:
//   BEEP_PREEMPT_EN  when defined, a pending game-over request aborts a
//                    hit or miss pattern and is granted straight into ARM.
// ----------------------------------------------------------------------------
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int NOTE_W  = DEF_NOTE_W
) (
    input  logic           clk_50MHz,
    input  logic           rst_n,
    beep_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    state_t           state;
    src_vec_t         pend;
    src_vec_t         grant_q;
    src_t             src_q;
    logic [IDX_W-1:0] note_idx_q;
    logic             busy_q;
    logic             done_q;

    src_t             pick;
    src_vec_t         pend_clr;
    logic             preempt;
    logic [NOTE_W-1:0] half;

    // ------------------------------------------------------------------
    // Arbitration: which source is taken this cycle and which pending
    // bit that consumes.
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        pick     = prio_pick(pend);
        preempt  = 1'b0;
        pend_clr = '0;
`ifdef BEEP_PREEMPT_EN
        // Game over may steal the buzzer from hit or miss, armed or playing.
        preempt  = (state == S_ARM || state == S_PLAY) &&
                   pend[SRC_OVER] && !grant_q[SRC_OVER];
`endif
        if (state == S_IDLE && pend != '0)
            pend_clr = src_onehot(pick);
        else if (preempt)
            pend_clr = src_onehot(SRC_OVER);
    end

    // ------------------------------------------------------------------
    // Scheduler FSM with pending register and registered outputs.
    // A request arriving on the same edge its bit is cleared wins, so the
    // request replays after the current pattern.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50MHz) begin
        if (rst_n) begin
            state      <= S_IDLE;
            pend       <= '0;
            grant_q    <= '0;
            src_q      <= SRC_HIT;
            note_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pend   <= (pend & ~pend_clr) | bus.req;
            done_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    note_idx_q <= '0;
                    if (pend != '0) begin
                        grant_q <= src_onehot(pick);
                        src_q   <= pick;
                        busy_q  <= 1'b1;
                        state   <= S_ARM;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end

                S_ARM: begin
                    if (preempt) begin
                        done_q     <= 1'b1;
                        grant_q    <= src_onehot(SRC_OVER);
                        src_q      <= SRC_OVER;
                        note_idx_q <= '0;
                    end else if (bus.rhythm_tick) begin
                        note_idx_q <= '0;
                        state      <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (preempt) begin
                        // Interrupted source is dropped, not re-queued.
                        done_q     <= 1'b1;
                        grant_q    <= src_onehot(SRC_OVER);
                        src_q      <= SRC_OVER;
                        note_idx_q <= '0;
                        state      <= S_ARM;
                    end else if (bus.rhythm_tick) begin
                        if (note_idx_q == LAST_IDX) begin
                            done_q     <= 1'b1;
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            note_idx_q <= '0;
                            state      <= S_IDLE;
                        end else begin
                            note_idx_q <= note_idx_q + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tone generation. The tick that advances the note (or ends the
    // pattern) restarts the generator on the same edge, so each note
    // starts from counter 0 and beep low. On ARM->PLAY the generator is
    // still disabled at that edge, which clears it just the same.
    // ------------------------------------------------------------------
    assign half = NOTE_W'(NOTES[src_q][note_idx_q]);

    beep_tone_gen #(
        .NOTE_W (NOTE_W)
    ) u_tone (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .restart   ((state == S_PLAY) && bus.rhythm_tick),
        .half      (half),
        .en        (state == S_PLAY),
        .beep      (bus.beep)
    );

    assign bus.busy     = busy_q;
    assign bus.grant    = grant_q;
    assign bus.note_idx = note_idx_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// ----------------------------------------------------------------------------
// tb_beep_scheduler
// Directed bench for beep_scheduler. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, i.e. reflecting the edge
// just taken. Expectations follow BEEP_PREEMPT_EN when it is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_beep_scheduler;

    localparam int SEQ_LEN = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    beep_scheduler_if #(.SEQ_LEN(SEQ_LEN)) bus ();

    beep_scheduler #(
        .SEQ_LEN (SEQ_LEN),
        .NOTE_W  (16)
    ) dut (
        .clk_50MHz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic tick();
        bus.rhythm_tick = 1'b1;
        step();
        bus.rhythm_tick = 1'b0;
    endtask

    task automatic pulse_req(input logic [2:0] v);
        bus.req = v;
        step();
        bus.req = 3'b000;
    endtask

    // Starting in ARM with grant g: one arming tick plus SEQ_LEN note ticks.
    task automatic run_pattern(input string tag, input logic [2:0] g);
        for (int i = 0; i <= SEQ_LEN; i++) begin
            gap(2);
            check({tag, "_grant"}, bus.grant, g);
            check({tag, "_busy"}, bus.busy, 1'b1);
            tick();
            if (i < SEQ_LEN) begin
                check({tag, "_idx"}, bus.note_idx, i);
                check({tag, "_nodone"}, bus.done, 1'b0);
            end else begin
                check({tag, "_done"}, bus.done, 1'b1);
                check({tag, "_grant_end"}, bus.grant, 3'b000);
                check({tag, "_busy_end"}, bus.busy, 1'b0);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req         = 3'b000;
        bus.rhythm_tick = 1'b0;

        // ---------------- reset with requests pulsing ----------------
        rst_n   = 1'b1;
        bus.req = 3'b111;
        gap(3);
        bus.req = 3'b000;
        check("rst_grant", bus.grant, 3'b000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_beep", bus.beep, 1'b0);
        check("rst_idx", bus.note_idx, 0);
        rst_n = 1'b0;
        gap(2);
        check("rst_pend_empty", bus.grant, 3'b000);
        check("rst_busy_after", bus.busy, 1'b0);

        // ---------------- single hit ----------------
        pulse_req(3'b001);
        check("hit_not_yet", bus.grant, 3'b000);
        step();
        check("hit_grant", bus.grant, 3'b001);
        check("hit_busy", bus.busy, 1'b1);
        gap(5);
        check("hit_arm_silent", bus.beep, 1'b0);
        tick();
        check("hit_n0_idx", bus.note_idx, 0);
        check("hit_n0_beep0", bus.beep, 1'b0);
        gap(47800);
        check("hit_before_toggle", bus.beep, 1'b0);
        step();
        check("hit_toggle", bus.beep, 1'b1);
        gap(3);
        tick();
        check("hit_n1_idx", bus.note_idx, 1);
        check("hit_n1_cleared", bus.beep, 1'b0);
        tick();
        tick();
        check("hit_n3_idx", bus.note_idx, 3);
        gap(50);
        check("hit_rest_silent", bus.beep, 1'b0);
        tick();
        check("hit_done", bus.done, 1'b1);
        check("hit_grant_end", bus.grant, 3'b000);
        check("hit_busy_end", bus.busy, 1'b0);
        step();
        check("hit_done_one_cycle", bus.done, 1'b0);
        check("hit_no_replay", bus.grant, 3'b000);

        // ---------------- priority: miss before hit ----------------
        pulse_req(3'b011);
        step();
        check("prio_first_miss", bus.grant, 3'b010);
        run_pattern("prio_miss", 3'b010);
        step();
        check("prio_then_hit", bus.grant, 3'b001);
        check("prio_done_low", bus.done, 1'b0);
        run_pattern("prio_hit", 3'b001);
        step();
        check("prio_idle", bus.grant, 3'b000);

        // ---------------- replay of the playing source ----------------
        pulse_req(3'b001);
        step();
        check("rep_grant", bus.grant, 3'b001);
        tick();
        tick();
        tick();
        check("rep_n2", bus.note_idx, 2);
        pulse_req(3'b001);
        tick();
        tick();
        check("rep_done1", bus.done, 1'b1);
        check("rep_gap", bus.grant, 3'b000);
        step();
        check("rep_again", bus.grant, 3'b001);
        run_pattern("rep_second", 3'b001);
        step();
        check("rep_no_third", bus.grant, 3'b000);

        // ---------- tick on grant edge ignored; set+clear replays ----------
        pulse_req(3'b001);
        bus.req         = 3'b001;
        bus.rhythm_tick = 1'b1;
        step();
        bus.req         = 3'b000;
        bus.rhythm_tick = 1'b0;
        check("coin_grant", bus.grant, 3'b001);
        for (int i = 0; i < SEQ_LEN; i++) begin
            gap(2);
            tick();
        end
        check("coin_not_done", bus.done, 1'b0);
        check("coin_still_busy", bus.busy, 1'b1);
        check("coin_last_idx", bus.note_idx, SEQ_LEN - 1);
        gap(2);
        tick();
        check("coin_done", bus.done, 1'b1);
        step();
        check("coin_replay", bus.grant, 3'b001);
        run_pattern("coin_second", 3'b001);
        step();
        check("coin_idle", bus.grant, 3'b000);

        // ---------------- game over during miss ----------------
        pulse_req(3'b010);
        step();
        check("pre_miss_grant", bus.grant, 3'b010);
        tick();
        tick();
        check("pre_miss_n1", bus.note_idx, 1);
        pulse_req(3'b100);
`ifdef BEEP_PREEMPT_EN
        step();
        check("pre_abort_done", bus.done, 1'b1);
        check("pre_over_grant", bus.grant, 3'b100);
        check("pre_over_busy", bus.busy, 1'b1);
        check("pre_over_idx", bus.note_idx, 0);
        check("pre_over_silent", bus.beep, 1'b0);
        run_pattern("pre_over", 3'b100);
        step();
        check("pre_miss_dropped", bus.grant, 3'b000);
`else
        step();
        check("nopre_no_done", bus.done, 1'b0);
        check("nopre_keep_miss", bus.grant, 3'b010);
        tick();
        tick();
        tick();
        check("nopre_miss_done", bus.done, 1'b1);
        check("nopre_gap", bus.grant, 3'b000);
        step();
        check("nopre_over_grant", bus.grant, 3'b100);
        run_pattern("nopre_over", 3'b100);
        step();
        check("nopre_idle", bus.grant, 3'b000);
`endif

        // ---------------- reset mid-pattern ----------------
        pulse_req(3'b001);
        step();
        tick();
        tick();
        tick();
        check("mrst_n2", bus.note_idx, 2);
        pulse_req(3'b010);
        gap(5);
        rst_n = 1'b1;
        step();
        check("mrst_grant", bus.grant, 3'b000);
        check("mrst_busy", bus.busy, 1'b0);
        check("mrst_beep", bus.beep, 1'b0);
        check("mrst_idx", bus.note_idx, 0);
        rst_n = 1'b0;
        gap(2);
        tick();
        gap(3);
        check("mrst_no_resume", bus.grant, 3'b000);
        check("mrst_pend_lost", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beep_scheduler.md
# beep_scheduler

Sound-effect scheduler for the whack-a-mole buzzer. It accepts one-cycle sound requests from the game logic (hit, miss, game over) and grants the single buzzer to one of them by fixed priority. It steps the granted source's 4-note pattern on each 3 Hz rhythm tick from the beep clock divider and drives the buzzer square wave. It sits between the game FSM and the board beeper pin.

## Interface
- SEQ_LEN, 4: notes per sound pattern; must be a power of two, ≥2.
- NOTE_W, 16: width of note half-period count, in clk_50MHz cycles.
- clk_50MHz  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous reset, active-high (asserted = 1, despite the name).
- rhythm_tick  in  1  one-cycle pulse at 3 Hz from the beep clock divider.
- req  in  3  one-cycle request pulses: bit0 hit, bit1 miss, bit2 game_over.
- busy  out  1  high while a pattern is armed or playing.
- grant  out  3  one-hot source currently owning the buzzer; 0 when idle.
- note_idx  out  $clog2(SEQ_LEN)  current step within the pattern.
- done  out  1  one-cycle pulse when a pattern completes or is aborted.
- beep  out  1  square-wave buzzer drive.

## Operation
- Pending register pend[2:0]: bit set on any cycle req[i]=1; cleared on the cycle source i is granted. A set and a clear of the same bit in one cycle leave it set, so the request replays.
- Priority: game_over > miss > hit.
- States:
  - IDLE: if pend≠0, grant the highest-priority pending source and go to ARM. Otherwise grant=0.
  - ARM: buzzer silent; on rhythm_tick go to PLAY with note_idx=0.
  - PLAY: on rhythm_tick, if note_idx=SEQ_LEN-1 then pulse done and go to IDLE; else note_idx+1.
- Note ROM: half = NOTES[src][note_idx]; half=0 means rest.
- Tone generation: counter runs 0..half-1 and beep toggles when it wraps. On every note change and on entering PLAY, the counter and beep clear to 0. While half=0, or outside PLAY, beep=0 and the counter is held at 0.
- A new request for the currently playing source is latched into pend and plays after the current pattern.
- Preemption is configurable (see Configuration).

## Timing
- Reset values: state IDLE, pend=0, grant=0, busy=0, note_idx=0, done=0, beep=0, tone counter=0.
- A req pulse at edge k sets pend at k. Grant and busy are visible after edge k+1 when the block is IDLE.
- First note starts the cycle after the first rhythm_tick seen in ARM. A rhythm_tick coinciding with the grant edge is ignored.
- Each note lasts exactly one rhythm period. A full pattern lasts SEQ_LEN ticks after arming.
- done, grant←0 and busy←0 all take effect on the edge that consumes the final tick.
- With pend≠0 at done, the next grant follows one cycle later via IDLE, so there is one idle cycle between patterns.
- Reset asserted mid-pattern returns the block to reset values on the next edge, and all pending requests are lost.
- A req pulse coincident with reset is dropped.

## Configuration
- BEEP_PREEMPT_EN defined:
  - If pend[2] is set while grant is hit or miss (ARM or PLAY), the current pattern aborts on the next edge.
  - On abort: done pulses, the interrupted source is not re-queued, and game_over is granted directly into ARM with no IDLE cycle.
- BEEP_PREEMPT_EN undefined: patterns always run to completion, and game_over waits in pend.

## Structure
- Package beep_pkg holds:
  - the source-index constants SRC_HIT=0, SRC_MISS=1, SRC_OVER=2;
  - the state enum;
  - the NOTES ROM constant [3][SEQ_LEN] of NOTE_W. Values: hit {47801,37936,31888,0}, miss {63776,0,63776,0}, game_over {47801,56818,63776,0}.
- Sub-module beep_tone_gen takes clk_50MHz, rst_n, a restart pulse, half[NOTE_W-1:0] and an enable, and outputs beep. It holds the counter and toggle logic.

## Test plan
- Reset behaviour: hold rst_n=1 for 3 cycles while pulsing req=3'b111 -> all outputs 0 and pend empty after release.
- Single hit: pulse req=001 -> grant=001 two edges later, beep=0 until the first tick. After that tick, beep toggles every 47801 cycles. After the 4th tick, done=1 for one cycle and grant=0. Note 3 (rest) keeps beep=0.
- Priority: pulse req=011 in the same cycle -> miss plays first, then one idle cycle, then hit plays. Total 2 done pulses.
- Replay: re-pulse hit during hit note 2 -> hit pattern plays twice back-to-back.
- Preemption with BEEP_PREEMPT_EN: pulse game_over during miss note 1 -> done the next edge, grant=100 with state ARM, and miss not replayed. Without the macro, miss completes and then game_over plays.
- Reset mid-pattern: assert rst_n during PLAY note 2 -> beep=0, grant=0 and busy=0 on the next edge, and the pattern does not resume.
